mul_rs_queue: RTL and testbench
===============================

# mul_rs_queue

Multi-entry, in-order reservation station for the multiply/divide/HILO unit. It replaces the single-slot station and decouples the unit from the execution pipe. It accepts up to two dispatched micro-ops per cycle and holds up to DEPTH of them in program order. Each entry snoops the CDB for missing operands, and the head entry is presented to the multiplier through a valid/ack handshake. Strict FIFO issue preserves HILO read/write ordering, so no HILO renaming is needed.

## Interface
- DEPTH, 4, entry count; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush; clears all entries.
- rs_taken  in  2  per-slot dispatch strobe.
- rs_i  in  2×reserve_station_t  dispatched entries; slot 0 is older.
- can_accept  out  2  bit0: ≥1 free entry; bit1: ≥2 free entries. Both are computed from the registered count.
- count  out  $clog2(DEPTH+1)  occupied entries (registered).
- cdb  in  cdb_packet_t  result broadcast for operand wakeup.
- issue_valid  out  1  head entry is valid and all its operands are ready.
- issue_entry  out  reserve_station_t  head entry with operands after the current-cycle CDB snoop.
- issue_ack  in  1  the unit consumes the head this cycle; legal only while issue_valid.

## Operation
- **Storage.** Circular buffer with log2(DEPTH)-bit head/tail pointers that wrap modulo DEPTH, plus a count register.
- **Dispatch order.**
  - Slots are written in order: slot 0 first, then slot 1.
  - If only rs_taken[1] is set, slot 1 is written at the tail.
  - Tail advances by popcount(rs_taken).
- **Dispatch precondition.**
  - The dispatch stage only asserts a strobe when can_accept permits it.
  - An excess write is discarded, with count saturating at DEPTH; a bench assertion flags it.
  - can_accept ignores a same-cycle issue_ack. This is conservative.
- **Wakeup.**
  - Every valid entry passes through read_operands against cdb every cycle, and the snooped result is written back.
  - A newly written entry is stored exactly as dispatched. It begins snooping the cycle after the write.
  - The dispatch stage is responsible for forwarding any CDB broadcast in the write cycle.
- **Issue.**
  - issue_valid = head.busy & &head.operand_ready, evaluated after the current-cycle snoop. A same-cycle CDB broadcast can therefore enable issue.
  - issue_entry holds the snooped head. It is '0 when the queue is empty.
  - issue_ack pops the head at the clock edge and advances head by one.
  - Entries behind a stalled head never issue, even if their operands are ready.
- **Simultaneous events.**
  - Pop and one or two pushes in the same cycle are all honoured: count_next = count − ack + popcount(taken).
  - At full, a pop with no push leaves DEPTH−1.
- **Flush / rst.**
  - Pointers, count and all busy bits are cleared.
  - issue_ack and dispatch strobes in the same cycle are ignored.
  - A flush asserted mid-operation must not leave stale operand_ready bits visible.

## Timing
- **Reset values:** issue_valid 0, issue_entry '0, count 0, can_accept 2'b11.
- **Dispatch to issue:**
  - An entry dispatched with all operands ready at cycle t and landing on an empty queue asserts issue_valid at t+1.
  - If the entry was waiting on a CDB tag broadcast at cycle u > t, issue_valid asserts at u.
- **Throughput:** one issue per cycle. After an ack at t, the next entry (if ready) drives issue_valid at t+1.
- **Counters:** count and can_accept update one cycle after the causing push or pop.
- **Combinational paths:** no combinational path from issue_ack to issue_valid. Snoop logic is the only cdb→issue path.

## Structure
- reserve_station_t, cdb_packet_t and rob_index_t stay in the shared cpu_defs package.
- Add the constant MUL_RS_DEPTH there; the instantiating module passes it as DEPTH.
- Sub-module: read_operands, instantiated once per entry (a generate loop of DEPTH instances).
- The multiplier and the HILO result muxing stay in the consuming unit, outside this block.

## Test plan
- **Reset/flush:**
  - Stimulus: fill 3 entries, assert flush.
  - Required: next cycle count=0, issue_valid=0, can_accept=2'b11. A dispatch in the flush cycle is absent.
- **Dual dispatch ordering:**
  - Stimulus: rs_taken=2'b11 with reorder 5 (slot 0) and 6 (slot 1), both ready, issue_ack held high.
  - Required: issue_entry.reorder = 5 then 6 on consecutive cycles.
- **Wakeup and in-order block:**
  - Stimulus: head (reorder 1) waits on tag 7; the second entry is ready.
  - Required: issue_valid=0 until the cycle cdb carries tag 7. In that same cycle, issue_valid=1 with the forwarded operand value.
- **Full boundary (DEPTH=4):**
  - Stimulus: dispatch 4 entries.
  - Required: count=4, can_accept=2'b00. Ack plus single push in the same cycle keeps count=4.
- **Wrap-around:**
  - Stimulus: 10 push/pop cycles at 1/cycle with reorder 0..9.
  - Required: issue order 0..9 and count never exceeds 2.
- **Rst mid-operation:**
  - Stimulus: assert rst while issue_valid=1 and issue_ack=1.
  - Required: next cycle all outputs are at reset values and no pop is double-counted.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU types: ROB index, reservation-station entry, CDB broadcast
// and the multiply/divide reservation-station depth.
package cpu_defs;

    localparam int ROB_W        = 5;
    localparam int MUL_RS_DEPTH = 4;

    typedef logic [ROB_W-1:0] rob_index_t;

    typedef struct packed {
        logic                   busy;
        logic [3:0]             fu_op;
        rob_index_t             reorder;
        logic [1:0]             operand_ready;
        rob_index_t [1:0]       operand_tag;
        logic [1:0][31:0]       operand;
    } reserve_station_t;

    typedef struct packed {
        logic        valid;
        rob_index_t  reorder;
        logic [31:0] value;
    } cdb_packet_t;

endpackage

// File: rtl/read_operands.sv
// Operand wakeup for one station entry: a pending operand whose tag matches
// the CDB broadcast captures the broadcast value and becomes ready.
module read_operands
    import cpu_defs::*;
(
    input  reserve_station_t entry_i,
    input  cdb_packet_t      cdb_i,
    output reserve_station_t entry_o
);

    always_comb begin
        entry_o = entry_i;
        for (int k = 0; k < 2; k++) begin
            if (entry_i.busy && !entry_i.operand_ready[k] && cdb_i.valid &&
                (cdb_i.reorder == entry_i.operand_tag[k])) begin
                entry_o.operand[k]       = cdb_i.value;
                entry_o.operand_ready[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_rs_queue.sv
// In-order reservation station for the multiply/divide/HILO unit: a circular
// buffer of DEPTH entries, dual dispatch, per-entry CDB snoop, FIFO issue.
module mul_rs_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = MUL_RS_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [1:0]                   rs_taken,
    input  reserve_station_t [1:0]       rs_i,
    output logic [1:0]                   can_accept,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  cdb_packet_t                  cdb,
    output logic                         issue_valid,
    output reserve_station_t             issue_entry,
    input  logic                         issue_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    reserve_station_t entries_q [DEPTH];
    reserve_station_t entries_d [DEPTH];
    reserve_station_t snooped   [DEPTH];
    reserve_station_t head_entry;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] slot1_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   free_slots;
    logic             pop, push0, push1;

    for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
        read_operands u_read_operands (
            .entry_i (entries_q[g]),
            .cdb_i   (cdb),
            .entry_o (snooped[g])
        );
    end

    // Issue sees the head after this cycle's snoop, so a broadcast can enable it.
    assign head_entry  = snooped[head_q];
    assign issue_valid = head_entry.busy & (&head_entry.operand_ready);
    assign issue_entry = head_entry.busy ? head_entry : '0;
    assign pop         = issue_ack & issue_valid;

    // Occupancy flags come from the registered count only; a same-cycle pop is ignored.
    assign can_accept  = {count_q <= CNT_W'(DEPTH - 2), count_q < CNT_W'(DEPTH)};
    assign count       = count_q;

    always_comb begin
        free_slots = (CNT_W+1)'(DEPTH) - (CNT_W+1)'(count_q) + (CNT_W+1)'(pop);
        push0      = rs_taken[0] && (free_slots != '0);
        push1      = rs_taken[1] && (free_slots > (CNT_W+1)'(push0));
        slot1_ptr  = push0 ? tail_q + PTR_W'(1) : tail_q;

        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = snooped[i];
        end
        // Pop clears first so a push landing on the freed slot (full queue) wins.
        if (pop)   entries_d[head_q]    = '0;
        if (push0) entries_d[tail_q]    = rs_i[0];
        if (push1) entries_d[slot1_ptr] = rs_i[1];

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push0) + PTR_W'(push1);
        count_d = count_q - CNT_W'(pop) + CNT_W'(push0) + CNT_W'(push1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mul_rs_queue.sv
// Bench for mul_rs_queue: a queue-based model compared every cycle, plus
// directed sequences with literal expectations.
module tb_mul_rs_queue;
    import cpu_defs::*;

    localparam int DEPTH = MUL_RS_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [1:0]             rs_taken;
    reserve_station_t [1:0] rs_i;
    logic [1:0]             can_accept;
    logic [CNT_W-1:0]       count;
    cdb_packet_t            cdb;
    logic                   issue_valid;
    reserve_station_t       issue_entry;
    logic                   issue_ack;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;
    reserve_station_t mq[$];

    mul_rs_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rs_taken    (rs_taken),
        .rs_i        (rs_i),
        .can_accept  (can_accept),
        .count       (count),
        .cdb         (cdb),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .issue_ack   (issue_ack)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic reserve_station_t mk(int r, bit rdy0 = 1'b1, int tag0 = 0,
                                            logic [31:0] v0 = 32'h0);
        reserve_station_t e;
        e                  = '0;
        e.busy             = 1'b1;
        e.fu_op            = 4'(r);
        e.reorder          = rob_index_t'(r);
        e.operand_ready    = {1'b1, rdy0};
        e.operand_tag[0]   = rob_index_t'(tag0);
        e.operand_tag[1]   = rob_index_t'(r);
        e.operand[0]       = rdy0 ? 32'(r + 100) : v0;
        e.operand[1]       = 32'(r * 3);
        return e;
    endfunction

    // A pending operand whose tag is on the CDB takes the value and becomes ready.
    function automatic reserve_station_t snoop(reserve_station_t e, cdb_packet_t c);
        reserve_station_t s;
        s = e;
        for (int k = 0; k < 2; k++) begin
            if (!e.operand_ready[k] && c.valid && c.reorder == e.operand_tag[k]) begin
                s.operand_ready[k] = 1'b1;
                s.operand[k]       = c.value;
            end
        end
        return s;
    endfunction

    // driver tasks
    task automatic idle();
        rs_taken  = '0;
        rs_i      = '0;
        issue_ack = 1'b0;
        flush     = 1'b0;
        cdb       = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    // scoreboard: model outputs from the current state and inputs, then advance it
    initial begin
        reserve_station_t exp_head;
        bit               exp_valid;
        int               room;
        int               npush;
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                exp_head  = (mq.size() > 0) ? snoop(mq[0], cdb) : '0;
                exp_valid = (mq.size() > 0) && (&exp_head.operand_ready);
                check("m_issue_valid", 128'(issue_valid), 128'(exp_valid));
                check("m_issue_entry", 128'(issue_entry), 128'(exp_head));
                check("m_count", 128'(count), 128'(mq.size()));
                check("m_can_accept", 128'(can_accept),
                      128'({mq.size() <= DEPTH - 2, mq.size() < DEPTH}));
                if (rst || flush) begin
                    mq.delete();
                end else begin
                    foreach (mq[i]) mq[i] = snoop(mq[i], cdb);
                    if (issue_ack) begin
                        check("ack_while_valid", 128'(exp_valid), 128'(1));
                        if (exp_valid) void'(mq.pop_front());
                    end
                    npush = int'(rs_taken[0]) + int'(rs_taken[1]);
                    room  = DEPTH - mq.size();
                    if (npush > 0) check("dispatch_room", 128'(npush <= room), 128'(1));
                    if (rs_taken[0] && mq.size() < DEPTH) mq.push_back(rs_i[0]);
                    if (rs_taken[1] && mq.size() < DEPTH) mq.push_back(rs_i[1]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fails %0d", n_fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #2;
        check("rst_issue_valid", 128'(issue_valid), 128'(0));
        check("rst_issue_entry", 128'(issue_entry), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_can_accept", 128'(can_accept), 128'(2'b11));

        // Reset/flush: fill three, flush with a dispatch in the same cycle
        tick(); rst = 1'b0; rs_taken = 2'b11; rs_i[0] = mk(1); rs_i[1] = mk(2);
        tick(); rs_taken = 2'b01; rs_i[0] = mk(3);
        tick(); flush = 1'b1; rs_taken = 2'b01; rs_i[0] = mk(4);
        #2; check("fill_count", 128'(count), 128'(3));
        tick(); #2;
        check("flush_count", 128'(count), 128'(0));
        check("flush_valid", 128'(issue_valid), 128'(0));
        check("flush_can_accept", 128'(can_accept), 128'(2'b11));
        check("flush_entry", 128'(issue_entry), 128'(0));
        tick(); #2;
        check("flush_dispatch_absent", 128'(count), 128'(0));

        // Dual dispatch ordering
        tick(); rs_taken = 2'b11; rs_i[0] = mk(5); rs_i[1] = mk(6);
        tick(); issue_ack = 1'b1; #2;
        check("dual_valid0", 128'(issue_valid), 128'(1));
        check("dual_first", 128'(issue_entry.reorder), 128'(5));
        tick(); issue_ack = 1'b1; #2;
        check("dual_second", 128'(issue_entry.reorder), 128'(6));
        tick(); #2;
        check("dual_drained", 128'(count), 128'(0));

        // Wakeup and in-order block
        tick(); rs_taken = 2'b11; rs_i[0] = mk(1, 1'b0, 7); rs_i[1] = mk(2);
        tick(); cdb = '{valid: 1'b1, reorder: 5'd9, value: 32'h55}; #2;
        check("wait_other_tag", 128'(issue_valid), 128'(0));
        tick(); #2;
        check("wait_blocked", 128'(issue_valid), 128'(0));
        tick(); cdb = '{valid: 1'b1, reorder: 5'd7, value: 32'hDEADBEEF}; #2;
        check("wake_valid", 128'(issue_valid), 128'(1));
        check("wake_fwd_value", 128'(issue_entry.operand[0]), 128'(32'hDEADBEEF));
        check("wake_reorder", 128'(issue_entry.reorder), 128'(1));
        tick(); issue_ack = 1'b1; #2;
        check("wake_kept_value", 128'(issue_entry.operand[0]), 128'(32'hDEADBEEF));
        check("wake_kept_ready", 128'(issue_entry.operand_ready), 128'(2'b11));
        tick(); issue_ack = 1'b1; #2;
        check("wake_next", 128'(issue_entry.reorder), 128'(2));
        tick();

        // Slot 1 only
        tick(); rs_taken = 2'b10; rs_i[1] = mk(20);
        tick(); issue_ack = 1'b1; #2;
        check("slot1_reorder", 128'(issue_entry.reorder), 128'(20));
        check("slot1_count", 128'(count), 128'(1));
        tick();

        // Full boundary
        tick(); rs_taken = 2'b11; rs_i[0] = mk(10); rs_i[1] = mk(11);
        tick(); rs_taken = 2'b11; rs_i[0] = mk(12); rs_i[1] = mk(13);
        tick(); #2;
        check("full_count", 128'(count), 128'(4));
        check("full_can_accept", 128'(can_accept), 128'(2'b00));
        tick(); issue_ack = 1'b1; rs_taken = 2'b01; rs_i[0] = mk(14); #2;
        check("full_head", 128'(issue_entry.reorder), 128'(10));
        tick(); #2;
        check("full_ack_push_count", 128'(count), 128'(4));
        for (int k = 0; k < 4; k++) begin
            tick(); issue_ack = 1'b1; #2;
            check("full_drain", 128'(issue_entry.reorder), 128'(11 + k));
        end
        tick(); #2;
        check("full_empty", 128'(count), 128'(0));

        // Wrap-around: one push and one pop per cycle
        for (int i = 0; i < 10; i++) begin
            tick(); rs_taken = 2'b01; rs_i[0] = mk(i);
            if (i > 0) issue_ack = 1'b1;
            #2;
            if (i > 0) check("wrap_order", 128'(issue_entry.reorder), 128'(i - 1));
            check("wrap_count_le2", 128'(count <= 2), 128'(1));
        end
        tick(); issue_ack = 1'b1; #2;
        check("wrap_last", 128'(issue_entry.reorder), 128'(9));
        tick();

        // Rst mid-operation with an ack in flight
        tick(); rs_taken = 2'b11; rs_i[0] = mk(21); rs_i[1] = mk(22);
        tick(); issue_ack = 1'b1; rst = 1'b1; #2;
        check("rstmid_valid", 128'(issue_valid), 128'(1));
        check("rstmid_head", 128'(issue_entry.reorder), 128'(21));
        tick(); rst = 1'b0; #2;
        check("rstmid_count", 128'(count), 128'(0));
        check("rstmid_issue_valid", 128'(issue_valid), 128'(0));
        check("rstmid_can_accept", 128'(can_accept), 128'(2'b11));
        check("rstmid_entry", 128'(issue_entry), 128'(0));
        tick(); rs_taken = 2'b01; rs_i[0] = mk(23);
        tick(); #2;
        check("rstmid_recount", 128'(count), 128'(1));
        check("rstmid_rehead", 128'(issue_entry.reorder), 128'(23));
        tick(); issue_ack = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
